// File: rtl/unsigned_product_accumulator.sv
// Burst accumulator for unsigned multiplier products: sums BURST_LEN accepted
// beats and presents the sum plus a sticky carry-out flag on a valid/ready output.
module unsigned_product_accumulator #(
  parameter int PROD_W    = 10,
  parameter int ACC_W     = 16,
  parameter int BURST_LEN = 8,
  localparam int CNT_W    = $clog2(BURST_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  output logic              prod_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_overflow,
  output logic [CNT_W-1:0]  beat_count
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state_p0;
  state_t             state_nxt;
  logic               ready_p0;
  logic [ACC_W-1:0]   acc_p0;
  logic               ovf_p0;
  logic [CNT_W-1:0]   cnt_p0;
  logic [ACC_W-1:0]   sum_p1;
  logic               ovf_p1;

  logic               accept;
  logic               last_beat;
  logic [PROD_W-1:0]  prod_masked;
  logic [ACC_W:0]     sum_ext;

  // Zero-extended add; the extra MSB is the carry out of the accumulator width.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [PROD_W-1:0] b);
    return {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
  endfunction

  assign accept      = prod_valid & ready_p0 & ~clear;
  assign last_beat   = accept & (cnt_p0 == LAST_BEAT);
  // Gate the operand so an undriven prod_data never reaches the adder.
  assign prod_masked = accept ? prod_data : '0;
  assign sum_ext     = acc_add(acc_p0, prod_masked);

  // Stage p0: FSM state register and registered upstream ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= ACCUM;
      ready_p0 <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      ready_p0 <= (state_nxt == ACCUM);
    end
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      ACCUM:   if (last_beat) state_nxt = HOLD;
      HOLD:    if (clear || out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    out_valid  = (state_p0 == HOLD);
    prod_ready = ready_p0;
  end

  // Stage p0: running accumulator, sticky carry and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0 <= '0;
      ovf_p0 <= 1'b0;
      cnt_p0 <= '0;
    end else if (clear || last_beat) begin
      acc_p0 <= '0;
      ovf_p0 <= 1'b0;
      cnt_p0 <= '0;
    end else if (accept) begin
      acc_p0 <= sum_ext[ACC_W-1:0];
      ovf_p0 <= ovf_p0 | sum_ext[ACC_W];
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  // Stage p1: completed burst result, held until the output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1 <= '0;
      ovf_p1 <= 1'b0;
    end else if (last_beat) begin
      sum_p1 <= sum_ext[ACC_W-1:0];
      ovf_p1 <= ovf_p0 | sum_ext[ACC_W];
    end
  end

  assign out_sum      = sum_p1;
  assign out_overflow = ovf_p1;
  assign beat_count   = cnt_p0;

endmodule

// File: tb/tb_unsigned_product_accumulator.sv
// Directed + random bench for unsigned_product_accumulator; a 16-bit and a 12-bit
// accumulator share one stimulus stream and one scoreboard of unbounded burst sums.
module tb_unsigned_product_accumulator;

  localparam int PROD_W = 10;
  localparam int BLEN   = 8;
  localparam int CNT_W  = $clog2(BLEN + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              prod_valid;
  logic [PROD_W-1:0] prod_data;
  logic              out_ready;

  logic              prod_ready, out_valid, out_overflow;
  logic [15:0]       out_sum;
  logic [CNT_W-1:0]  beat_count;
  logic              prod_ready12, out_valid12, ovf12;
  logic [11:0]       sum12;
  logic [CNT_W-1:0]  beat_count12;

  int unsigned exp_q[$];
  int unsigned acc_m;
  int          cnt_m;
  int          ncmp;
  int          nfail;
  int          results_seen;

  always #5 clk = ~clk;

  unsigned_product_accumulator #(.PROD_W(PROD_W), .ACC_W(16), .BURST_LEN(BLEN)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid),
    .prod_data(prod_data), .prod_ready(prod_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_overflow(out_overflow),
    .beat_count(beat_count)
  );

  unsigned_product_accumulator #(.PROD_W(PROD_W), .ACC_W(12), .BURST_LEN(BLEN)) dut12 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid),
    .prod_data(prod_data), .prod_ready(prod_ready12), .out_valid(out_valid12),
    .out_ready(out_ready), .out_sum(sum12), .out_overflow(ovf12),
    .beat_count(beat_count12)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Observe the handshakes that will happen at the coming edge, update the
  // scoreboard, then advance to just after that edge.
  task automatic tick();
    int unsigned t;
    @(negedge clk);
    if (clear) begin
      acc_m = 0;
      cnt_m = 0;
      if (out_valid && exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      if (out_valid && out_ready) begin
        results_seen++;
        if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
        else begin
          t = exp_q.pop_front();
          check("sum16", 32'(out_sum), t % 65536);
          check("ovf16", 32'(out_overflow), 32'(t >= 65536));
          check("valid12", 32'(out_valid12), 32'd1);
          check("sum12", 32'(sum12), t % 4096);
          check("ovf12", 32'(ovf12), 32'(t >= 4096));
        end
      end
      if (prod_valid && prod_ready) begin
        acc_m += 32'(prod_data);
        cnt_m++;
        if (cnt_m == BLEN) begin
          exp_q.push_back(acc_m);
          acc_m = 0;
          cnt_m = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PROD_W-1:0] d);
    bit got;
    got = 1'b0;
    prod_valid = 1'b1;
    prod_data  = d;
    for (int i = 0; i < 50 && !got; i++) begin
      got = prod_ready;
      tick();
    end
    if (!got) check("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    ncmp = 0; nfail = 0; acc_m = 0; cnt_m = 0; results_seen = 0;
    rst_n = 1'b0; clear = 1'b0; prod_valid = 1'b0; prod_data = '0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_prod_ready", 32'(prod_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_beat_count", 32'(beat_count), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_overflow", 32'(out_overflow), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_prod_ready", 32'(prod_ready), 32'd1);

    // 8 x 961 back-to-back, result held with out_ready low
    for (int i = 0; i < BLEN - 1; i++) send(10'd961);
    check("beats_before_last", 32'(beat_count), 32'(BLEN - 1));
    check("valid_before_last", 32'(out_valid), 32'd0);
    send(10'd961);
    prod_valid = 1'b0;
    check("latency_out_valid", 32'(out_valid), 32'd1);
    check("burst_out_sum", 32'(out_sum), 32'd7688);
    check("burst_out_ovf", 32'(out_overflow), 32'd0);
    check("burst_beat_count", 32'(beat_count), 32'd0);
    check("burst12_out_sum", 32'(sum12), 32'd3592);
    check("burst12_out_ovf", 32'(ovf12), 32'd1);

    // Backpressure: upstream offers beats that must be ignored
    prod_valid = 1'b1;
    prod_data  = 10'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_sum", 32'(out_sum), 32'd7688);
      check("bp_prod_ready", 32'(prod_ready), 32'd0);
      check("bp_beat_count", 32'(beat_count), 32'd0);
    end
    prod_valid = 1'b0;
    out_ready  = 1'b1;
    tick();
    out_ready  = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_prod_ready", 32'(prod_ready), 32'd1);
    check("release_beat_count", 32'(beat_count), 32'd0);

    // Overflow flag does not carry into the next burst
    for (int i = 0; i < BLEN; i++) send(10'd1);
    prod_valid = 1'b0;
    out_ready  = 1'b1;
    tick();

    // Clear mid-burst drops the coincident beat
    for (int i = 0; i < 3; i++) send(10'd100);
    prod_data = 10'd50;
    clear     = 1'b1;
    tick();
    clear      = 1'b0;
    prod_valid = 1'b0;
    check("clear_beat_count", 32'(beat_count), 32'd0);
    for (int i = 0; i < BLEN; i++) send(10'd10);
    prod_valid = 1'b0;
    tick();
    check("after_clear_out_valid", 32'(out_valid), 32'd0);

    // Clear in HOLD discards the pending result
    out_ready = 1'b0;
    for (int i = 0; i < BLEN; i++) send(10'd3);
    prod_valid = 1'b0;
    check("hold_out_valid", 32'(out_valid), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("hold_clear_out_valid", 32'(out_valid), 32'd0);
    check("hold_clear_prod_ready", 32'(prod_ready), 32'd1);

    // Asynchronous reset mid-burst
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(10'd7);
    prod_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_beat_count", 32'(beat_count), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_prod_ready", 32'(prod_ready), 32'd0);
    check("arst12_beat_count", 32'(beat_count12), 32'd0);
    acc_m = 0;
    cnt_m = 0;
    #1 rst_n = 1'b1;
    tick();
    for (int i = 0; i < BLEN; i++) send(10'd2);
    prod_valid = 1'b0;
    tick();

    // Random products with random upstream gaps and downstream stalls
    begin
      int target;
      target = results_seen + 100;
      for (int c = 0; c < 20000 && results_seen < target; c++) begin
        prod_valid = ($urandom_range(0, 3) != 0);
        prod_data  = prod_valid ? PROD_W'($urandom_range(0, 31) * $urandom_range(0, 31)) : 'x;
        out_ready  = ($urandom_range(0, 2) != 0);
        tick();
      end
      check("random_results", 32'(results_seen), 32'(target));
    end
    prod_valid = 1'b0;
    prod_data  = '0;
    out_ready  = 1'b1;
    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
